// File: rtl/f_mant_div_if.sv
// f_mant_div_if: operand and result valid/ready bundle for the significand divider.
interface f_mant_div_if #(parameter int QBITS = 27);
    logic             in_valid;
    logic             in_ready;
    logic [22:0]      a;
    logic [22:0]      b;
    logic             out_valid;
    logic             out_ready;
    logic [QBITS-1:0] q;
    logic             sticky;
    logic             norm;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, q, sticky, norm);
    modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, q, sticky, norm);
endinterface

// File: rtl/f_mant_div.sv
// f_mant_div: iterative radix-2 restoring divider for single-precision significands.
// Define F_DIV_EARLY_TERM_EN to finish as soon as the partial remainder becomes zero.
module f_mant_div #(
    parameter int QBITS = 27
) (
    input logic        clk,
    input logic        rst_n,
    f_mant_div_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
`ifdef F_DIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    logic [1:0]       state;
    logic [25:0]      r;
    logic [23:0]      d;
    logic [4:0]       cnt;
    logic [QBITS-1:0] qr;
    logic             sticky_r;
    logic             ge;
    logic [25:0]      diff;
    logic [25:0]      r_nx;
    logic [QBITS-1:0] q_nx;
    logic             stop;
    always_comb begin
        ge   = r >= {2'b00, d};
        diff = ge ? r - {2'b00, d} : r;
        r_nx = {diff[24:0], 1'b0};
        q_nx = {qr[QBITS-2:0], ge};
        stop = (cnt == 5'd0) || (EARLY && r_nx == 26'd0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            r        <= '0;
            d        <= '0;
            cnt      <= '0;
            qr       <= '0;
            sticky_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    r     <= {2'b00, 1'b1, bus.a};
                    d     <= {1'b1, bus.b};
                    cnt   <= 5'(QBITS - 1);
                    qr    <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    r   <= r_nx;
                    cnt <= cnt - 5'd1;
                    // an early stop left-aligns the quotient; cnt is zero on a normal finish
                    qr  <= stop ? q_nx << cnt : q_nx;
                    if (stop) begin
                        sticky_r <= r_nx != 26'd0;
                        state    <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.q         = qr;
    assign bus.sticky    = sticky_r;
    assign bus.norm      = qr[QBITS-1];
endmodule

// File: tb/tb_f_mant_div.sv
// tb_f_mant_div: scoreboard bench for f_mant_div; directed vectors, backpressure, reset abort, random traffic.
module tb_f_mant_div;
    localparam int QB = 27;
    typedef struct packed {
        logic [QB-1:0] q;
        logic          s;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    f_mant_div_if #(.QBITS(QB)) bus ();
    f_mant_div #(.QBITS(QB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    bit rnd_done = 1'b0;
    logic [22:0] da[4] = '{23'h000000, 23'h000000, 23'h400000, 23'h7FFFFF};
    logic [22:0] db[4] = '{23'h000000, 23'h400000, 23'h000000, 23'h000000};
    exp_t de[4] = '{'{27'h4000000, 1'b0}, '{27'h2AAAAAA, 1'b1},
                    '{27'h6000000, 1'b0}, '{27'h7FFFFF8, 1'b0}};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [22:0] a, input logic [22:0] b);
        logic [63:0] n, dv, qq, rm;
        n  = {40'd0, 1'b1, a} << 26;
        dv = {40'd0, 1'b1, b};
        qq = n / dv;
        rm = n % dv;
        return '{qq[QB-1:0], rm != 64'd0};
    endfunction

    function automatic int exp_lat(input exp_t e);
`ifdef F_DIV_EARLY_TERM_EN
        int tz = 0;
        if (e.s) return QB;
        while (tz < QB - 1 && !e.q[tz]) tz++;
        return QB - tz;
`else
        return QB;
`endif
    endfunction

    task automatic issue(input logic [22:0] a, input logic [22:0] b, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%0b expected 1", bus.in_ready);
            return;
        end
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        sb.push_back(e);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!bus.out_valid && n < 200);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !bus.in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", {63'd0, bus.in_ready}, 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got q=%0h expected no result", bus.q);
            end else begin
                e = sb.pop_front();
                chk("q", bus.q, e.q);
                chk("sticky", bus.sticky, e.s);
                chk("norm", bus.norm, e.q[QB-1]);
            end
        end
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {bus.in_ready, bus.out_valid, bus.q, bus.sticky, bus.norm},
            {2'b10, 27'd0, 2'b00});
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(da[i], db[i], de[i]);
            wait_valid(n);
            chk("latency", n, exp_lat(de[i]));
        end
        drain();
        bus.out_ready = 1'b0;
        issue(23'h000000, 23'h400000, de[1]);
        wait_valid(n);
        chk("bp_latency", n, QB);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold", {bus.q, bus.sticky, bus.norm, bus.in_ready, bus.out_valid},
                {27'h2AAAAAA, 4'b1001});
            bus.in_valid = i[0];
            bus.a = 23'h7FFFFF;
            bus.b = 23'h123456;
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
        issue(23'h000000, 23'h000000, de[0]);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        void'(sb.pop_back());
        #1 chk("abort_reset", {bus.in_ready, bus.out_valid, bus.q}, {2'b10, 27'd0});
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(23'h000000, 23'h400000, de[1]);
        wait_valid(n);
        chk("post_abort_latency", n, QB);
        drain();
        fork
            begin
                logic [22:0] ra, rb;
                for (int i = 0; i < 1000; i++) begin
                    ra = 23'($urandom);
                    rb = 23'($urandom);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    issue(ra, rb, model(ra, rb));
                end
                rnd_done = 1'b1;
            end
            begin
                int g = 0;
                while ((!rnd_done || sb.size() != 0) && g < 80000) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                    g++;
                end
                bus.out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/f_mant_div.md
Name: f_mant_div

Overview:
- Iterative radix-2 restoring divider for single-precision significands. It is the inverse operation to the mantissa multiply path.
- Takes two 23-bit fraction fields and restores the hidden 1 on each, giving dividend 1.a and divisor 1.b.
- Produces a QBITS-wide quotient plus a sticky bit for the downstream rounding/exception unit.
- Sits in the F datapath beside the multiply/FMA unit and uses valid/ready handshakes on input and output.

Parameters:
- QBITS, 27, number of quotient bits generated. Bit QBITS-1 is the integer bit, the rest are fractional. 27 = 24 significand + guard + round + 1 normalisation. Legal range 25..32.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider idle, can accept.
- a  input  23  dividend fraction; significand is {1,a}.
- b  input  23  divisor fraction; significand is {1,b}.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- q  output  QBITS  quotient, q = floor({1,a}/{1,b} * 2^(QBITS-1)).
- sticky  output  1  final remainder non-zero.
- norm  output  1  equals q[QBITS-1]; 1 means quotient >= 1.0, 0 means result needs 1-bit left normalisation.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, q=0, sticky=0, norm=0, internal remainder/divisor/counter=0.
- Reset asserted mid-operation aborts immediately. Result is discarded, block returns to IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, load R = {2'b00,1,a} (26 bits), D = {1,b}, cnt = QBITS-1, q register = 0; go to BUSY.
- BUSY:
  - in_ready=0.
  - Each edge: if R >= D then q_bit=1, R=(R-D)<<1; else q_bit=0, R=R<<1.
  - q register shifts left, inserting q_bit.
  - cnt decrements. On the edge where cnt==0, go to DONE.
  - Exactly QBITS BUSY edges.
- DONE:
  - out_valid=1. q/sticky/norm hold constant while out_ready=0.
  - sticky = (R != 0) after the last iteration.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - in_ready stays 0 in DONE. No accept in the same cycle as result handoff.
- Latency: out_valid is first high QBITS edges after the accept edge. Minimum initiation interval is QBITS+2 cycles.
- Arithmetic and width rules:
  - Remainder stays < 2D < 2^25; 26-bit R never overflows.
  - Divisor >= 1.0 always, so no divide-by-zero case exists.
  - Quotient range (0.5, 2), so at least one of q[QBITS-1] or q[QBITS-2] is set.
- in_valid while not IDLE is ignored. a and b are sampled only on the accept edge.
- Upstream holds a/b/in_valid until in_ready.

Optional Feature:
- Macro: F_DIV_EARLY_TERM_EN.
- When defined:
  - In BUSY, if the post-iteration remainder is zero, go to DONE on that edge.
  - q is left-aligned by shifting the q register left by the remaining cnt, so the remaining low bits are 0.
  - sticky=0 in this case.
  - Latency becomes variable, from 1 to QBITS edges. Result values are bit-identical to the non-early build.
- When undefined: fixed QBITS-edge latency as above.

Test Plan:
- Reset check: rst_n=0 -> in_ready=1, out_valid=0, q=0, sticky=0. Reset pulse during BUSY at iteration 10 -> returns to IDLE next cycle with out_valid=0, then next op completes correctly.
- a=0, b=0 (1.0/1.0) -> q=27'h4000000, norm=1, sticky=0, out_valid exactly 27 edges after accept. With F_DIV_EARLY_TERM_EN: 1 edge.
- a=0, b=23'h400000 (1.0/1.5) -> q=27'h2AAAAAA, norm=0, sticky=1, fixed latency in both builds.
- a=23'h400000, b=0 (1.5/1.0) -> q=27'h6000000, sticky=0. a=23'h7FFFFF, b=0 -> q=27'h7FFFFF8, sticky=0.
- Backpressure: out_ready=0 for 20 cycles after done -> q/sticky/norm stable, in_ready=0. in_valid pulsed in DONE is ignored. Then out_ready=1 -> IDLE next edge.
- Back-to-back: 1000 random a/b with random in_valid/out_ready gaps -> every q/sticky matches reference floor({1,a}*2^26/{1,b}) and remainder test, with no lost or duplicated results.
